// File: rtl/strobe_arbiter.sv
// Round-robin scheduler feeding one toggle-strobe clock-crossing channel, with strobe spacing.
// Optional build macro STROBE_ARB_ACK_EN: WAIT ends on a returned ack (with timeout) instead of a fixed holdoff.
module strobe_arbiter #(
    parameter int NREQ    = 4,
    parameter int SRCW    = 2,
    parameter int WIDTH   = 8,
    parameter int HOLDOFF = 8,
    parameter int TIMEOUT = 256
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*WIDTH-1:0] data_in,
    output logic [NREQ-1:0]       grant,
    output logic                  strobe_out,
    output logic [WIDTH-1:0]      data_out,
    output logic [SRCW-1:0]       src_out,
    output logic                  busy,
    input  logic                  ack_in,
    output logic                  timeout_err
);

    localparam logic ST_IDLE = 1'b0;
    localparam logic ST_WAIT = 1'b1;
    localparam logic [15:0] CNT_MAX = 16'hFFFF;

    logic            state;
    logic [15:0]     cnt;
    logic [SRCW-1:0] ptr;
    logic [SRCW-1:0] sel, sel_hi, sel_lo;
    logic            found_hi;
    logic            any_req;
    logic [NREQ-1:0] sel_onehot;
    logic [WIDTH-1:0] sel_data;
    logic            wait_done;

    assign any_req = |req;

    // Round robin: lowest set index above ptr wins, otherwise wrap to the lowest set index.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        sel_hi     = '0;
        sel_lo     = '0;
        found_hi   = 1'b0;
        sel_onehot = '0;
        sel_data   = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                sel_lo = SRCW'(i);
                if (i > int'(ptr)) begin
                    sel_hi   = SRCW'(i);
                    found_hi = 1'b1;
                end
            end
        end
        sel = found_hi ? sel_hi : sel_lo;
        for (int i = 0; i < NREQ; i++) begin
            if (SRCW'(i) == sel) begin
                sel_onehot[i] = 1'b1;
                sel_data      = data_in[i*WIDTH +: WIDTH];
            end
        end
    end

`ifdef STROBE_ARB_ACK_EN
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);
    localparam int unused_holdoff = HOLDOFF;

    logic ack_seen;
    logic tmo_hit;
    logic err_q;

    // cnt is 0 only in the strobe cycle, so an ack there is ignored; ack beats a same-cycle timeout.
    assign ack_seen  = ack_in && (cnt != 16'd0);
    assign tmo_hit   = !ack_seen && (cnt == TMO_LAST);
    assign wait_done = ack_seen || tmo_hit;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (state == ST_WAIT && tmo_hit) begin
            err_q <= 1'b1;
        end
    end

    assign timeout_err = err_q;
`else
    localparam logic [15:0] HOLD_LAST = 16'(HOLDOFF - 1);
    localparam int unused_timeout = TIMEOUT;

    logic unused_ack;
    assign unused_ack  = ack_in;
    assign wait_done   = (cnt == HOLD_LAST);
    assign timeout_err = 1'b0;
`endif

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            ptr        <= SRCW'(NREQ - 1);
            grant      <= '0;
            strobe_out <= 1'b0;
            data_out   <= '0;
            src_out    <= '0;
            busy       <= 1'b0;
        end else begin
            grant      <= '0;
            strobe_out <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (any_req) begin
                        grant      <= sel_onehot;
                        strobe_out <= 1'b1;
                        data_out   <= sel_data;
                        src_out    <= sel;
                        ptr        <= sel;
                        busy       <= 1'b1;
                        cnt        <= '0;
                        state      <= ST_WAIT;
                    end
                end
                default: begin
                    if (cnt != CNT_MAX) begin
                        cnt <= cnt + 16'd1;
                    end
                    if (wait_done) begin
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_strobe_arbiter.sv
// Self-checking bench for strobe_arbiter: directed scenarios plus random traffic against a
// cycle-count reference model (strobe times, rotation order, spacing, ack/timeout when built in).
module tb_strobe_arbiter;

    localparam int NREQ    = 4;
    localparam int SRCW    = 2;
    localparam int WIDTH   = 8;
    localparam int HOLDOFF = 8;
    localparam int TIMEOUT = 16;
    localparam int VW      = NREQ + 1 + WIDTH + SRCW + 2;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [NREQ-1:0]       req;
    logic [NREQ*WIDTH-1:0] data_in;
    logic                  ack_in;
    logic [NREQ-1:0]       grant;
    logic                  strobe_out;
    logic [WIDTH-1:0]      data_out;
    logic [SRCW-1:0]       src_out;
    logic                  busy;
    logic                  timeout_err;

    strobe_arbiter #(
        .NREQ(NREQ), .SRCW(SRCW), .WIDTH(WIDTH), .HOLDOFF(HOLDOFF), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rst(rst), .req(req), .data_in(data_in), .grant(grant),
        .strobe_out(strobe_out), .data_out(data_out), .src_out(src_out), .busy(busy),
        .ack_in(ack_in), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: elapsed cycles since the last strobe decide when the channel frees up.
    int               cyc;
    bit               m_idle;
    int               m_last;
    int               m_ptr;
    bit               m_err;
    logic [WIDTH-1:0] m_data;
    int               m_src;
    logic [VW-1:0]    exp_v;

    function automatic logic [VW-1:0] dut_v();
        return {grant, strobe_out, data_out, src_out, busy, timeout_err};
    endfunction

    task automatic model_reset();
        m_idle = 1'b1;
        m_last = -100000;
        m_ptr  = NREQ - 1;
        m_err  = 1'b0;
        m_data = '0;
        m_src  = 0;
        exp_v  = '0;
    endtask

    task automatic cycle(input logic [NREQ-1:0] r, input logic [NREQ*WIDTH-1:0] d, input logic a);
        logic [NREQ-1:0] g;
        bit              s;
        int              sel;
        req     = r;
        data_in = d;
        ack_in  = a;
        g       = '0;
        s       = 1'b0;
        if (m_idle && r != '0) begin
            sel = -1;
            for (int k = 1; k <= NREQ; k++) begin
                if (sel < 0 && r[(m_ptr + k) % NREQ]) sel = (m_ptr + k) % NREQ;
            end
            g[sel] = 1'b1;
            s      = 1'b1;
            m_data = d[sel*WIDTH +: WIDTH];
            m_src  = sel;
            m_ptr  = sel;
            m_last = cyc + 1;
            m_idle = 1'b0;
        end else if (!m_idle) begin
`ifdef STROBE_ARB_ACK_EN
            if (a && cyc > m_last) m_idle = 1'b1;
            else if (cyc - m_last == TIMEOUT - 1) begin
                m_idle = 1'b1;
                m_err  = 1'b1;
            end
`else
            if (cyc + 1 - m_last >= HOLDOFF) m_idle = 1'b1;
`endif
        end
        @(posedge clk);
        #1;
        cyc++;
        exp_v = {g, s, m_data, SRCW'(m_src), !m_idle, m_err};
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req = '0;
        ack_in = 1'b0;
        #1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    function automatic logic [NREQ*WIDTH-1:0] rand_data();
        logic [31:0] w;
        w = $urandom;
        return w[NREQ*WIDTH-1:0];
    endfunction

    task automatic wait_strobe(input logic [NREQ-1:0] r, input int exp_src, input string name);
        bit seen = 1'b0;
        for (int n = 0; n < 40 && !seen; n++) begin
            cycle(r, rand_data(), 1'b0);
            checks++;
            if (dut_v() !== exp_v) begin
                errors++;
                $display("FAIL %s model cyc=%0d got=%h want=%h", name, cyc, dut_v(), exp_v);
            end
            if (strobe_out === 1'b1) begin
                seen = 1'b1;
                checks++;
                if (src_out !== SRCW'(exp_src)) begin
                    errors++;
                    $display("FAIL %s src got=%0d want=%0d", name, src_out, exp_src);
                end
            end
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL %s no strobe within 40 cycles", name);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; req = '0; data_in = '0; ack_in = 1'b0;
        cyc = 0;
        model_reset();
        #2;
        checks++;
        if (dut_v() !== '0) begin
            errors++;
            $display("FAIL reset_outputs got=%h want=0", dut_v());
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_single();
        logic [NREQ*WIDTH-1:0] d;
        d = rand_data();
        d[WIDTH-1:0] = 8'h5A;
        cycle(4'b0001, d, 1'b0);
        checks++;
        if ({grant, strobe_out, data_out, src_out, busy} !== {4'b0001, 1'b1, 8'h5A, 2'd0, 1'b1}) begin
            errors++;
            $display("FAIL single_grant got g=%b s=%b d=%h src=%0d b=%b want g=0001 s=1 d=5a src=0 b=1",
                     grant, strobe_out, data_out, src_out, busy);
        end
        for (int k = 1; k <= HOLDOFF + 1; k++) begin
            cycle('0, rand_data(), 1'b0);
            checks++;
            if (busy !== (k < HOLDOFF) || strobe_out !== 1'b0 || data_out !== 8'h5A) begin
                errors++;
                $display("FAIL single_hold T+%0d busy=%b strobe=%b data=%h want busy=%b strobe=0 data=5a",
                         k, busy, strobe_out, data_out, (k < HOLDOFF));
            end
            checks++;
            if (dut_v() !== exp_v) begin
                errors++;
                $display("FAIL single_model cyc=%0d got=%h want=%h", cyc, dut_v(), exp_v);
            end
        end
    endtask

    task automatic test_round_robin();
        logic [NREQ*WIDTH-1:0] d;
        int strobes = 0;
        int last = -1;
        d = {8'h13, 8'h12, 8'h11, 8'h10};
        do_reset();
        for (int n = 0; n < 60 && strobes < 5; n++) begin
            cycle(4'b1111, d, 1'b0);
            checks++;
            if (dut_v() !== exp_v) begin
                errors++;
                $display("FAIL rr_model cyc=%0d got=%h want=%h", cyc, dut_v(), exp_v);
            end
            if (strobe_out === 1'b1) begin
                checks++;
                if (src_out !== SRCW'(strobes % NREQ) || data_out !== WIDTH'(8'h10 + strobes % NREQ)) begin
                    errors++;
                    $display("FAIL rr_order #%0d src=%0d data=%h want src=%0d data=%h",
                             strobes, src_out, data_out, strobes % NREQ, 8'h10 + strobes % NREQ);
                end
                if (last >= 0) begin
                    checks++;
                    if (cyc - last !== HOLDOFF + 1) begin
                        errors++;
                        $display("FAIL rr_period got=%0d want=%0d", cyc - last, HOLDOFF + 1);
                    end
                end
                last = cyc;
                strobes++;
            end
        end
        if (strobes < 5) begin
            checks++;
            errors++;
            $display("FAIL rr_count got=%0d want=5", strobes);
        end
    endtask

    task automatic test_drop();
        do_reset();
        wait_strobe(4'b0010, 1, "drop_first");
        wait_strobe(4'b1010, 3, "drop_to3");
        wait_strobe(4'b1010, 1, "drop_back1");
        cycle(4'b1010, rand_data(), 1'b0);
        cycle(4'b1010, rand_data(), 1'b0);
        wait_strobe(4'b0010, 1, "drop_released3");
    endtask

    task automatic test_mid_reset();
        do_reset();
        wait_strobe(4'b0100, 2, "mid_first");
        cycle('0, rand_data(), 1'b0);
        cycle('0, rand_data(), 1'b0);
        rst = 1'b1;
        #1;
        checks++;
        if (dut_v() !== '0) begin
            errors++;
            $display("FAIL mid_reset_async got=%h want=0", dut_v());
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        wait_strobe(4'b1100, 2, "mid_ptr_restart");
    endtask

`ifdef STROBE_ARB_ACK_EN
    task automatic test_ack();
        do_reset();
        wait_strobe(4'b0001, 0, "ack_first");
        cycle('0, rand_data(), 1'b1);
        cycle('0, rand_data(), 1'b0);
        cycle('0, rand_data(), 1'b0);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL ack_at_T_ignored busy=%b want=1", busy);
        end
        cycle('0, rand_data(), 1'b1);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL ack_release busy=%b want=0", busy);
        end
        cycle(4'b0001, rand_data(), 1'b0);
        checks++;
        if (strobe_out !== 1'b1 || dut_v() !== exp_v) begin
            errors++;
            $display("FAIL ack_next_strobe got=%h want=%h", dut_v(), exp_v);
        end
        for (int k = 1; k <= TIMEOUT + 1; k++) begin
            cycle('0, rand_data(), 1'b0);
            checks++;
            if (timeout_err !== (k >= TIMEOUT) || busy !== (k < TIMEOUT)) begin
                errors++;
                $display("FAIL ack_timeout T+%0d err=%b busy=%b want err=%b busy=%b",
                         k, timeout_err, busy, (k >= TIMEOUT), (k < TIMEOUT));
            end
        end
        wait_strobe(4'b0010, 1, "ack_after_timeout");
        checks++;
        if (timeout_err !== 1'b1) begin
            errors++;
            $display("FAIL ack_sticky err=%b want=1", timeout_err);
        end
        do_reset();
        checks++;
        if (timeout_err !== 1'b0) begin
            errors++;
            $display("FAIL ack_err_clear err=%b want=0", timeout_err);
        end
    endtask
`endif

    task automatic test_random();
        logic [NREQ-1:0] r;
        logic            a;
        do_reset();
        for (int n = 0; n < 800; n++) begin
            r = ($urandom_range(0, 4) == 0) ? '0 : NREQ'($urandom_range(0, (1 << NREQ) - 1));
            a = ($urandom_range(0, 9) == 0);
            cycle(r, rand_data(), a);
            checks++;
            if (dut_v() !== exp_v) begin
                errors++;
                $display("FAIL random cyc=%0d req=%b got=%h want=%h", cyc, r, dut_v(), exp_v);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_drop();
        test_mid_reset();
`ifdef STROBE_ARB_ACK_EN
        test_ack();
`endif
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
